// File: rtl/ldlt_pkg.sv
// Shared definitions for the LDL^T triangular solver: state encoding,
// default word format and load-sequence sizing.
package ldlt_pkg;

   localparam int DEF_DATA_LEN = 34;
   localparam int DEF_FRACTION = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_FWD  = 3'd2,
      ST_DIAG = 3'd3,
      ST_BWD  = 3'd4,
      ST_OUT  = 3'd5
   } ldlt_state_e;

   // Number of factor words (D plus strict lower L) for an order-dim system.
   function automatic int tri_words(input int dim);
      return dim * (dim + 1) / 2;
   endfunction

   // Full load sequence: factor words followed by dim RHS words.
   function automatic int load_words(input int dim);
      return tri_words(dim) + dim;
   endfunction

endpackage

// File: rtl/ldlt_solve_if.sv
// Streaming port bundle between the LDL^T factor stage, the solver and the
// solution consumer.
//
// Handshake: an input word transfers on a rising clk edge where i_valid and
// o_ready are both 1; i_valid may drop at any time to stall without loss.
// The output side has no backpressure: o_data is meaningful exactly on
// cycles where o_valid is 1 and is held at 0 otherwise.
interface ldlt_solve_if
   import ldlt_pkg::*;
#(
   parameter int DATA_LEN = DEF_DATA_LEN
);

   logic                       i_start;
   logic                       i_valid;
   logic signed [DATA_LEN-1:0] i_data;
   logic                       o_ready;
   logic                       o_valid;
   logic signed [DATA_LEN-1:0] o_data;
   logic                       o_err;

   modport master (
      output i_start, i_valid, i_data,
      input  o_ready, o_valid, o_data, o_err
   );

   modport slave (
      input  i_start, i_valid, i_data,
      output o_ready, o_valid, o_data, o_err
   );

endinterface

// File: rtl/fx_mac.sv
// Fixed-point multiply-subtract: res = acc - ((a*b) >>> FRACTION), product
// kept at double width, result wrapped back to DATA_LEN bits.
module fx_mac
   import ldlt_pkg::*;
#(
   parameter int DATA_LEN = DEF_DATA_LEN,
   parameter int FRACTION = DEF_FRACTION
) (
   input  logic signed [DATA_LEN-1:0] acc_i,
   input  logic signed [DATA_LEN-1:0] a_i,
   input  logic signed [DATA_LEN-1:0] b_i,
   output logic signed [DATA_LEN-1:0] res_o
);

   localparam int PW = 2 * DATA_LEN;

   logic signed [PW-1:0] prod;

   always_comb begin
      prod  = PW'(a_i) * PW'(b_i);
      res_o = acc_i - DATA_LEN'(prod >>> FRACTION);
   end

endmodule

// File: rtl/ldlt_solve.sv
// Solves L*D*L^T*x = b from a streamed factor/RHS sequence: forward
// substitution, diagonal scaling, back substitution, then streams x out.
module ldlt_solve
   import ldlt_pkg::*;
#(
   parameter int DATA_LEN = DEF_DATA_LEN,
   parameter int FRACTION = DEF_FRACTION,
   parameter int DIM      = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   ldlt_solve_if.slave bus,
   output ldlt_state_e dbg_state_o
);

   localparam int IW     = $clog2(DIM);
   localparam int TRI_W  = tri_words(DIM);
   localparam int LOAD_W = load_words(DIM);
   localparam int WW     = $clog2(LOAD_W + 1);
   localparam int PW     = 2 * DATA_LEN;

   localparam logic [IW-1:0] LAST = IW'(DIM - 1);

   typedef logic signed [DATA_LEN-1:0] word_t;

   ldlt_state_e   state_q, state_d;
   logic [IW-1:0] row_q, row_d;
   logic [IW-1:0] col_q, col_d;
   logic [WW-1:0] words_q, words_d;
   word_t         acc_q, acc_d;
   logic          err_q, err_d;
   logic          ready_q, ready_d;
   logic          valid_q, valid_d;
   word_t         data_q, data_d;

   // Storage is fully rewritten by every load before it is read.
   word_t lmat [DIM][DIM];
   word_t dvec [DIM];
   word_t vec  [DIM];

   logic          v_we, d_we, l_we;
   word_t         v_wd;
   logic          first_term;
   word_t         acc_in, l_sel, mac_out, piv, quot;
   logic          piv_zero;
   logic          accept, bphase;
   logic signed [PW-1:0] num, den;

   // The same accumulator path serves FWD (row ascending, k rising) and
   // BWD (row descending, k falling from DIM-1); the first term seeds from vec.
   always_comb begin
      first_term = (state_q == ST_BWD) ? (col_q == LAST) : (col_q == '0);
      acc_in     = first_term ? vec[row_q] : acc_q;
      l_sel      = (state_q == ST_BWD) ? lmat[col_q][row_q] : lmat[row_q][col_q];
      piv        = dvec[row_q];
      piv_zero   = (piv == '0);
      num        = PW'(vec[row_q]) <<< FRACTION;
      den        = piv_zero ? PW'(1) : PW'(piv);
      quot       = piv_zero ? '0 : DATA_LEN'(num / den);
      accept     = ready_q && bus.i_valid;
      bphase     = (words_q >= WW'(TRI_W));
   end

   fx_mac #(
      .DATA_LEN (DATA_LEN),
      .FRACTION (FRACTION)
   ) u_mac (
      .acc_i (acc_in),
      .a_i   (l_sel),
      .b_i   (vec[col_q]),
      .res_o (mac_out)
   );

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      words_d = words_q;
      acc_d   = acc_q;
      err_d   = err_q;
      valid_d = 1'b0;
      data_d  = '0;
      v_we    = 1'b0;
      d_we    = 1'b0;
      l_we    = 1'b0;
      v_wd    = bus.i_data;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_start) begin
               state_d = ST_LOAD;
               err_d   = 1'b0;
               row_d   = '0;
               col_d   = '0;
               words_d = '0;
            end
         end

         ST_LOAD: begin
            if (accept) begin
               words_d = words_q + WW'(1);
               if (bphase) begin
                  v_we = 1'b1;
                  if (words_q == WW'(LOAD_W - 1)) begin
                     state_d = ST_FWD;
                     row_d   = '0;
                     col_d   = '0;
                  end else begin
                     row_d = row_q + IW'(1);
                  end
               end else begin
                  d_we = (row_q == col_q);
                  l_we = (row_q != col_q);
                  // Column-major walk of the lower triangle, then RHS from row 0.
                  if (row_q == LAST) begin
                     col_d = (col_q == LAST) ? '0 : col_q + IW'(1);
                     row_d = (col_q == LAST) ? '0 : col_q + IW'(1);
                  end else begin
                     row_d = row_q + IW'(1);
                  end
               end
            end
         end

         ST_FWD: begin
            if (col_q == row_q) begin
               v_we  = 1'b1;
               v_wd  = acc_in;
               col_d = '0;
               if (row_q == LAST) begin
                  state_d = ST_DIAG;
                  row_d   = '0;
               end else begin
                  row_d = row_q + IW'(1);
               end
            end else begin
               acc_d = mac_out;
               col_d = col_q + IW'(1);
            end
         end

         ST_DIAG: begin
            v_we  = 1'b1;
            v_wd  = quot;
            err_d = err_q | piv_zero;
            if (row_q == LAST) begin
               state_d = ST_BWD;
               row_d   = LAST;
               col_d   = LAST;
            end else begin
               row_d = row_q + IW'(1);
            end
         end

         ST_BWD: begin
            if (col_q == row_q) begin
               v_we  = 1'b1;
               v_wd  = acc_in;
               col_d = LAST;
               if (row_q == '0) begin
                  state_d = ST_OUT;
               end else begin
                  row_d = row_q - IW'(1);
               end
            end else begin
               acc_d = mac_out;
               col_d = col_q - IW'(1);
            end
         end

         ST_OUT: begin
            valid_d = 1'b1;
            data_d  = vec[row_q];
            if (row_q == LAST) begin
               state_d = ST_IDLE;
               row_d   = '0;
            end else begin
               row_d = row_q + IW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
            words_d = '0;
         end
      endcase

      ready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         words_q <= '0;
         acc_q   <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         words_q <= words_d;
         acc_q   <= acc_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (v_we) vec[row_q]         <= v_wd;
      if (d_we) dvec[col_q]        <= bus.i_data;
      if (l_we) lmat[row_q][col_q] <= bus.i_data;
   end

   assign bus.o_ready = ready_q;
   assign bus.o_valid = valid_q;
   assign bus.o_data  = data_q;
   assign bus.o_err   = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ldlt_solve.sv
// Bench for ldlt_solve at DIM=3: directed solves, stalls, zero pivot,
// reset abort, then randomized systems against a plain-arithmetic model.
module tb_ldlt_solve;
  import ldlt_pkg::*;

  localparam int DW   = 34;
  localparam int FR   = 16;
  localparam int DIM  = 3;
  localparam int LAT  = DIM * (DIM + 2) + 1;
  localparam int ONE  = 65536;

  typedef logic signed [DW-1:0] word_t;

  logic        clk;
  logic        rst_n;
  ldlt_state_e dbg_state;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          last_b_edge = 0;

  word_t       lm [DIM][DIM];
  word_t       dv [DIM];
  word_t       bv [DIM];
  logic [DW-1:0] exp_q [$];

  ldlt_solve_if #(.DATA_LEN(DW)) bus ();

  ldlt_solve #(
    .DATA_LEN (DW),
    .FRACTION (FR),
    .DIM      (DIM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model: products and quotient follow the fixed-point rules
  function automatic word_t fxmul(input word_t a, input word_t b);
    logic signed [2*DW-1:0] p;
    p = (2*DW)'(a) * (2*DW)'(b);
    p = p >>> FR;
    return word_t'(p[DW-1:0]);
  endfunction

  function automatic word_t fxdiv(input word_t z, input word_t d);
    logic signed [2*DW-1:0] n, q;
    n = (2*DW)'(z);
    n = n <<< FR;
    q = n / (2*DW)'(d);
    return word_t'(q[DW-1:0]);
  endfunction

  function automatic bit model_push();
    word_t z [DIM];
    word_t y [DIM];
    word_t x [DIM];
    bit    err = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      z[i] = bv[i];
      for (int k = 0; k < i; k++) z[i] = z[i] - fxmul(lm[i][k], z[k]);
    end
    for (int i = 0; i < DIM; i++) begin
      if (dv[i] == 0) begin
        y[i] = '0;
        err  = 1'b1;
      end else begin
        y[i] = fxdiv(z[i], dv[i]);
      end
    end
    for (int i = DIM - 1; i >= 0; i--) begin
      x[i] = y[i];
      for (int k = i + 1; k < DIM; k++) x[i] = x[i] - fxmul(lm[k][i], x[k]);
    end
    for (int i = 0; i < DIM; i++) exp_q.push_back(x[i]);
    return err;
  endfunction

  function automatic word_t rnd_s(input int lo, input int hi);
    int t;
    t = int'($urandom_range(hi - lo, 0)) + lo;
    return word_t'(t);
  endfunction

  task automatic set_diag(input word_t d);
    for (int i = 0; i < DIM; i++) begin
      dv[i] = d;
      for (int k = 0; k < DIM; k++) lm[i][k] = '0;
    end
  endtask

  // driver tasks (called on a falling edge, return on a falling edge)
  task automatic start_solve();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("ready_in_load", 64'(bus.o_ready), 64'(1));
    chk("err_cleared", 64'(bus.o_err), 64'(0));
    chk("state_load", 64'(dbg_state), 64'(ST_LOAD));
  endtask

  task automatic send_word(input word_t w, input bit stall);
    int n = 0;
    if (stall) begin
      bus.i_valid = 1'b0;
      @(negedge clk);
    end
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) chk("ready_timeout", 64'(bus.o_ready), 64'(1));
    bus.i_valid = 1'b1;
    bus.i_data  = w;
    last_b_edge = cyc + 1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
  endtask

  task automatic load_all(input bit stall);
    for (int j = 0; j < DIM; j++)
      for (int i = j; i < DIM; i++)
        send_word((i == j) ? dv[j] : lm[i][j], stall);
    for (int i = 0; i < DIM; i++) send_word(bv[i], stall);
  endtask

  // scoreboard: drains exp_q against the output stream
  task automatic collect(input int inj, input bit exp_err);
    int got = 0;
    bit done = 1'b0;
    logic [DW-1:0] w, e;
    for (int n = 0; n < 200 && !done; n++) begin
      bus.i_start = (n == inj);
      @(negedge clk);
      w = bus.o_data;
      if (n == inj) chk("start_ignored", 64'(dbg_state), 64'(ST_FWD));
      if (bus.o_valid) begin
        if (got == 0) chk("latency", 64'(cyc - last_b_edge), 64'(LAT));
        if (exp_q.size() == 0) begin
          chk("stray_valid", 64'(bus.o_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("x_out", 64'(w), 64'(e));
        end
        got++;
      end else begin
        chk("idle_data", 64'(w), 64'(0));
        if (got > 0) done = 1'b1;
      end
    end
    bus.i_start = 1'b0;
    if (!done) chk("out_timeout", 64'(done), 64'(1));
    chk("out_count", 64'(got), 64'(DIM));
    chk("err_flag", 64'(bus.o_err), 64'(exp_err));
    chk("back_idle", 64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic run_solve(input bit stall, input int inj, input bit exp_err);
    start_solve();
    load_all(stall);
    collect(inj, exp_err);
  endtask

  task automatic push3(input int a, input int b, input int c);
    logic [DW-1:0] t;
    t = DW'(a); exp_q.push_back(t);
    t = DW'(b); exp_q.push_back(t);
    t = DW'(c); exp_q.push_back(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(bus.o_ready), 64'(0));
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'(0));
    chk({tag, "_data"}, 64'(bus.o_data), 64'(0));
    chk({tag, "_err"}, 64'(bus.o_err), 64'(0));
    chk({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    bit e;
    int n;
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // identity
    set_diag(word_t'(ONE));
    bv[0] = word_t'(ONE); bv[1] = word_t'(2*ONE); bv[2] = word_t'(3*ONE);
    push3(ONE, 2*ONE, 3*ONE);
    run_solve(1'b0, -1, 1'b0);

    // scaled diagonal
    set_diag(word_t'(2*ONE));
    bv[0] = word_t'(2*ONE); bv[1] = word_t'(4*ONE); bv[2] = word_t'(6*ONE);
    push3(ONE, 2*ONE, 3*ONE);
    run_solve(1'b0, -1, 1'b0);

    // coupled
    set_diag(word_t'(ONE));
    lm[1][0] = word_t'(32768);
    bv[0] = word_t'(ONE); bv[1] = word_t'(ONE); bv[2] = '0;
    push3(49152, 32768, 0);
    run_solve(1'b0, -1, 1'b0);

    // zero pivot: err sticks through IDLE until the next start
    set_diag(word_t'(ONE));
    dv[1] = '0;
    bv[0] = word_t'(ONE); bv[1] = word_t'(2*ONE); bv[2] = word_t'(3*ONE);
    push3(ONE, 0, 3*ONE);
    run_solve(1'b0, -1, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(bus.o_err), 64'(1));
    chk("err_idle_state", 64'(dbg_state), 64'(ST_IDLE));

    // coupled with stalls and a start pulse during FWD
    set_diag(word_t'(ONE));
    lm[1][0] = word_t'(32768);
    bv[0] = word_t'(ONE); bv[1] = word_t'(ONE); bv[2] = '0;
    push3(49152, 32768, 0);
    run_solve(1'b1, 2, 1'b0);

    // reset during BWD of a zero-pivot solve, then a clean identity solve
    set_diag(word_t'(ONE));
    dv[1] = '0;
    start_solve();
    load_all(1'b0);
    n = 0;
    while (dbg_state != ST_BWD && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bwd", 64'(dbg_state), 64'(ST_BWD));
    chk("err_before_rst", 64'(bus.o_err), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (4) begin
      @(negedge clk);
      chk("rst_hold_valid", 64'(bus.o_valid), 64'(0));
    end
    rst_n = 1'b1;
    exp_q.delete();
    repeat (30) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(bus.o_valid), 64'(0));
    end
    set_diag(word_t'(ONE));
    bv[0] = word_t'(ONE); bv[1] = word_t'(2*ONE); bv[2] = word_t'(3*ONE);
    push3(ONE, 2*ONE, 3*ONE);
    run_solve(1'b0, -1, 1'b0);

    // randomized systems
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DIM; i++) begin
        for (int k = 0; k < DIM; k++) lm[i][k] = (k < i) ? rnd_s(-ONE, ONE) : '0;
        dv[i] = ($urandom_range(0, 4) == 0) ? '0 : rnd_s(ONE / 2, 4 * ONE);
        if ($urandom_range(0, 1) == 1) dv[i] = -dv[i];
        bv[i] = rnd_s(-4 * ONE, 4 * ONE);
      end
      e = model_push();
      run_solve(1'($urandom_range(0, 1)), -1, e);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
